// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register, with a 1-entry response buffer.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [4:0]  if_rs,
    output logic [4:0]  if_rt,
    output logic [4:0]  if_rd,
    output logic [15:0] if_imm,
    output logic [5:0]  if_funct,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;

    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0]  if_instr_q, if_instr_d;

    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;

    logic         accept;
    logic         ifid_free;
    logic         rsp_take;
    logic         ifid_load;

    // A full response buffer means the decode side is backed up, so no new request goes out.
    assign imem_req  = (state_q == S_REQ) && !buf_valid_q;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;
    assign ifid_free = !if_valid_q || !stall_in;
    assign rsp_take  = (state_q == S_WAIT) && imem_rvalid;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_instr_d    = if_instr_q;
        buf_valid_d   = buf_valid_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        ifid_load     = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            if_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            // Any request already accepted must have its response swallowed in DRAIN.
            case (state_q)
                S_REQ:   state_d = accept ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            if (buf_valid_q && ifid_free) begin
                if_valid_d    = 1'b1;
                if_pc_d       = buf_pc_q;
                if_pc_plus4_d = buf_pc_q + 32'd4;
                if_instr_d    = buf_instr_q;
                buf_valid_d   = 1'b0;
                ifid_load     = 1'b1;
            end else if (rsp_take && ifid_free) begin
                if_valid_d    = 1'b1;
                if_pc_d       = fetch_pc_q;
                if_pc_plus4_d = fetch_pc_q + 32'd4;
                if_instr_d    = imem_rdata;
                ifid_load     = 1'b1;
            end else if (rsp_take) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = fetch_pc_q;
                buf_instr_d = imem_rdata;
            end else if (!stall_in) begin
                if_valid_d = 1'b0;
            end

            case (state_q)
                S_REQ: begin
                    if (accept) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d    = S_REQ;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_instr_q    <= 32'h0;
            buf_valid_q   <= 1'b0;
            buf_pc_q      <= 32'h0;
            buf_instr_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
            buf_valid_q   <= buf_valid_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
        end
    end

    // IF/ID register outputs and instruction field decode
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;
    assign if_opcode   = if_instr_q[31:26];
    assign if_rs       = if_instr_q[25:21];
    assign if_rt       = if_instr_q[20:16];
    assign if_rd       = if_instr_q[15:11];
    assign if_imm      = if_instr_q[15:0];
    assign if_funct    = if_instr_q[5:0];

`ifdef IF_PERF_COUNTERS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ifid_load)      fetch_cnt_d = sat_inc32(fetch_cnt_q);
        if (redirect_valid) flush_cnt_d = sat_inc16(flush_cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    logic perf_unused;
    assign perf_unused    = ifid_load;
    assign perf_fetch_cnt = 32'h0;
    assign perf_flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: an abstract fetch-stream model checked every cycle, plus literal spot checks.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_pc_plus4, if_instr;
    logic [5:0]  if_opcode, if_funct;
    logic [4:0]  if_rs, if_rt, if_rd;
    logic [15:0] if_imm;
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;

    logic        w_imem_req, w_rvalid, w_if_valid;
    logic [31:0] w_imem_addr, w_rdata, w_if_pc, w_if_pc_plus4, w_if_instr, w_perf_fetch;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm, w_perf_flush;

    int errors = 0;
    int checks = 0;

    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          data_fixed;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .if_opcode(if_opcode), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_imm(if_imm), .if_funct(if_funct),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall_in(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4), .if_instr(w_if_instr),
        .if_opcode(w_opcode), .if_rs(w_rs), .if_rt(w_rt), .if_rd(w_rd),
        .if_imm(w_imm), .if_funct(w_funct),
        .perf_fetch_cnt(w_perf_fetch), .perf_flush_cnt(w_perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return data_fixed ? 32'h2002_0005 : (a ^ 32'h8C43_A000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: memory sees acceptance before the edge, answers mem_lat edges later.
    task automatic cyc();
        bit          acc, wacc;
        logic [31:0] waddr;
        acc   = !reset && imem_req && imem_ready;
        wacc  = !reset && w_imem_req;
        waddr = w_imem_addr;
        if (acc) begin
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
        @(posedge clk);
        #2;
        imem_rvalid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_fn(mem_addr);
            end
        end
        w_rvalid = wacc;
        if (wacc) w_rdata = waddr ^ 32'h8C43_A000;
    endtask

    // Abstract model: queue of delivered-but-unconsumed instructions, next fetch address, request epoch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch;
    int          m_epoch = 0;
    bit          m_pv;
    int          m_pep;
    logic [31:0] m_paddr;
    logic [31:0] m_fcnt;
    logic [15:0] m_rcnt;
    bit          prev_hold;
    logic [31:0] p_pc, p_plus4, p_instr;

    always @(negedge clk) begin
        bit          exp_req, acc, consume, kept;
        int          old_n;
        logic [31:0] kaddr;
        entry_t      e;
        if (reset) begin
            mq.delete();
            m_fetch   = 32'h0;
            m_pv      = 1'b0;
            m_fcnt    = 32'h0;
            m_rcnt    = 16'h0;
            prev_hold = 1'b0;
        end else begin
            exp_req = !m_pv && (mq.size() < 2);
            chk("m_if_valid", 32'(if_valid), 32'(mq.size() != 0));
            chk("m_imem_req", 32'(imem_req), 32'(exp_req));
            chk("m_imem_addr", imem_addr, m_fetch);
            if (mq.size() != 0) begin
                chk("m_if_pc", if_pc, mq[0].pc);
                chk("m_if_pc_plus4", if_pc_plus4, mq[0].pc + 32'd4);
                chk("m_if_instr", if_instr, mq[0].instr);
                chk("m_opcode", 32'(if_opcode), (mq[0].instr >> 26) & 32'h3F);
                chk("m_rs", 32'(if_rs), (mq[0].instr >> 21) & 32'h1F);
                chk("m_rt", 32'(if_rt), (mq[0].instr >> 16) & 32'h1F);
                chk("m_rd", 32'(if_rd), (mq[0].instr >> 11) & 32'h1F);
                chk("m_imm", 32'(if_imm), mq[0].instr & 32'hFFFF);
                chk("m_funct", 32'(if_funct), mq[0].instr & 32'h3F);
            end
            if (prev_hold) begin
                chk("hold_pc", if_pc, p_pc);
                chk("hold_plus4", if_pc_plus4, p_plus4);
                chk("hold_instr", if_instr, p_instr);
            end
`ifdef IF_PERF_COUNTERS_EN
            chk("m_perf_fetch", perf_fetch_cnt, m_fcnt);
            chk("m_perf_flush", 32'(perf_flush_cnt), 32'(m_rcnt));
`else
            chk("m_perf_fetch", perf_fetch_cnt, 32'h0);
            chk("m_perf_flush", 32'(perf_flush_cnt), 32'h0);
`endif
            prev_hold = if_valid && stall_in && !redirect_valid;
            p_pc      = if_pc;
            p_plus4   = if_pc_plus4;
            p_instr   = if_instr;

            acc     = exp_req && imem_ready;
            consume = (mq.size() != 0) && !stall_in;
            kept    = imem_rvalid && m_pv && (m_pep == m_epoch) && !redirect_valid;
            kaddr   = m_paddr;
            old_n   = mq.size();
            if (imem_rvalid) m_pv = 1'b0;
            if (acc) begin
                m_pv    = 1'b1;
                m_pep   = m_epoch;
                m_paddr = m_fetch;
            end
            if (redirect_valid) begin
                mq.delete();
                m_fetch = {redirect_pc[31:2], 2'b00};
                m_epoch++;
                if (m_rcnt != 16'hFFFF) m_rcnt++;
            end else begin
                if (consume) void'(mq.pop_front());
                if (kept) begin
                    e.pc    = kaddr;
                    e.instr = mem_fn(kaddr);
                    mq.push_back(e);
                    m_fetch = kaddr + 32'd4;
                end
                if (((kept && old_n == 0) || (consume && mq.size() != 0)) && m_fcnt != 32'hFFFF_FFFF)
                    m_fcnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0;
        mem_lat = 1; mem_cnt = 0; mem_addr = 32'h0; data_fixed = 1'b1;
        cyc(); cyc();
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        reset = 1'b0;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wait_no_req", 32'(imem_req), 32'h0);
        cyc();
        chk("seq0_valid", 32'(if_valid), 32'h1);
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_rt", 32'(if_rt), 32'h2);
        chk("seq0_imm", 32'(if_imm), 32'h5);
        chk("seq0_addr", imem_addr, 32'h4);
        chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", w_if_pc_plus4, 32'h0);
        chk("wrap_second_addr", w_imem_addr, 32'h0);
        data_fixed = 1'b0;
        cyc(); cyc();
        chk("seq1_pc", if_pc, 32'h4);
        cyc(); cyc();
        chk("seq2_pc", if_pc, 32'h8);
        chk("seq2_instr", if_instr, 32'h8C43_A008);

        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        stall_in = 1'b0;
        cyc();
        chk("unstall_pc", if_pc, 32'hC);
        chk("unstall_instr", if_instr, 32'h8C43_A00C);
        chk("unstall_addr", imem_addr, 32'h10);

        mem_lat = 2;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        cyc();
        redirect_valid = 1'b0;
        chk("rdw_addr", imem_addr, 32'h40);
        chk("rdw_valid", 32'(if_valid), 32'h0);
        mem_lat = 1;
        cyc();
        chk("drain_req", 32'(imem_req), 32'h1);
        chk("drain_valid", 32'(if_valid), 32'h0);
        cyc(); cyc();
        chk("rdw_pc", if_pc, 32'h40);
        chk("rdw_opcode", 32'(if_opcode), 32'h23);
        chk("rdw_rt", 32'(if_rt), 32'h3);
        chk("rdw_imm", 32'(if_imm), 32'hA040);

        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_addr", imem_addr, 32'h44);
            chk("bp_req", 32'(imem_req), 32'h1);
            chk("bp_valid", 32'(if_valid), 32'h0);
        end
        imem_ready = 1'b1;
        cyc(); cyc();
        chk("bp_pc", if_pc, 32'h44);
        chk("bp_next_addr", imem_addr, 32'h48);

        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cyc();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        chk("rdq_addr", imem_addr, 32'h100);
        chk("rdq_req", 32'(imem_req), 32'h1);
        cyc(); cyc();
        chk("rdq_pc", if_pc, 32'h100);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cyc();
        redirect_valid = 1'b0;
        chk("rdr_addr", imem_addr, 32'h200);
        chk("rdr_valid", 32'(if_valid), 32'h0);
        cyc(); cyc();
        chk("rdr_pc", if_pc, 32'h200);
`ifdef IF_PERF_COUNTERS_EN
        chk("perf_fetch_8", perf_fetch_cnt, 32'd8);
        chk("perf_flush_3", 32'(perf_flush_cnt), 32'd3);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
        chk("perf_flush_off", 32'(perf_flush_cnt), 32'd0);
`endif

        stall_in = 1'b1; mem_lat = 3;
        cyc();
        chk("pre_rst_valid", 32'(if_valid), 32'h1);
        #1;
        reset = 1'b1; mem_cnt = 0; imem_rvalid = 1'b0; w_rvalid = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        chk("arst_plus4", if_pc_plus4, 32'h0);
        chk("arst_fetch_cnt", perf_fetch_cnt, 32'h0);
        chk("arst_flush_cnt", 32'(perf_flush_cnt), 32'h0);
        stall_in = 1'b0; mem_lat = 1;
        cyc();
        reset = 1'b0;
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", 32'(imem_req), 32'h1);
        cyc(); cyc();
        chk("restart_pc", if_pc, 32'h0);
        chk("restart_valid", 32'(if_valid), 32'h1);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
